// File: rtl/srdhm_mul_seq.sv
// srdhm_mul_seq: iterative signed 32x32->64 multiplier that feeds the SRDHM rounding stage.
//
// Operands are captured as unsigned magnitudes together with the sign of the result. The
// magnitudes are multiplied by retiring BITS_PER_CYCLE multiplier bits per BUSY cycle, and the
// sign is applied on the last cycle. Every operation takes the same number of cycles, including
// zero operands.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        synchronous active-high reset
//   in_valid     operands a/b valid
//   in_ready     block can accept operands (IDLE only)
//   a, b         signed 32-bit multiplicand / multiplier
//   out_valid    prod_top/prod_bottom/sat valid (DONE only)
//   out_ready    consumer accepts the result
//   prod_top     product bits [63:32]
//   prod_bottom  product bits [31:0]
//   sat          result came from INT32_MIN x INT32_MIN
module srdhm_mul_seq #(
  parameter int unsigned BITS_PER_CYCLE = 4  // 1, 2, 4 or 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod_top,
  output logic [31:0] prod_bottom,
  output logic        sat
);

  localparam int unsigned N    = 32 / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(N + 1);

  localparam logic [CntW-1:0] CntLoad = CntW'(N);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [31:0] IntMin = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Multiplicand magnitude, pre-shifted into place for the current group of multiplier bits.
  logic [63:0]     mcand_q;
  // Remaining multiplier magnitude; its low BITS_PER_CYCLE bits are the current group.
  logic [31:0]     mplier_q;
  logic [63:0]     acc_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_q;
  logic            sat_r_q;
  logic [63:0]     prod_q;
  logic            sat_q;

  logic                      accept;
  logic                      last_busy;
  logic [31:0]               abs_a;
  logic [31:0]               abs_b;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [63:0]               partial;
  logic [63:0]               acc_sum;
  logic [63:0]               result;

  // ---------------------------------------------------------------------------------------------
  // Operand conditioning and per-cycle partial product
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    // Two's-complement negate of INT32_MIN wraps back to 32'h80000000, which is exactly |INT32_MIN|
    // when read as unsigned.
    abs_a = a[31] ? (~a + 32'd1) : a;
    abs_b = b[31] ? (~b + 32'd1) : b;

    digit   = mplier_q[BITS_PER_CYCLE-1:0];
    partial = mcand_q * 64'(digit);
    acc_sum = acc_q + partial;

    // Negating a zero magnitude yields zero, so a zero product never gets a nonzero top half.
    result = neg_q ? (~acc_sum + 64'd1) : acc_sum;
  end

  assign accept    = (state_q == StIdle) && in_valid;
  assign last_busy = (state_q == StBusy) && (cnt_q == CntOne);

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == CntOne) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StBusy:  ;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sat_r_q  <= 1'b0;
      prod_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      if (accept) begin
        mcand_q  <= {32'd0, abs_a};
        mplier_q <= abs_b;
        acc_q    <= '0;
        cnt_q    <= CntLoad;
        neg_q    <= a[31] ^ b[31];
        sat_r_q  <= (a == IntMin) && (b == IntMin);
      end else if (state_q == StBusy) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << BITS_PER_CYCLE;
        mplier_q <= mplier_q >> BITS_PER_CYCLE;
        cnt_q    <= cnt_q - CntOne;
      end

      // Result registers hold their value through DONE and IDLE until the next completion.
      if (last_busy) begin
        prod_q <= result;
        sat_q  <= sat_r_q;
      end
    end
  end

  assign prod_top    = prod_q[63:32];
  assign prod_bottom = prod_q[31:0];
  assign sat         = sat_q;

endmodule

// File: tb/tb_srdhm_mul_seq.sv
// Directed and random bench for srdhm_mul_seq. Three instances share clock and reset:
// index 0 uses BITS_PER_CYCLE=4, index 1 uses 1, index 2 uses 8.
module tb_srdhm_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [31:0] a_s         [3];
  logic [31:0] b_s         [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [31:0] top_s       [3];
  logic [31:0] bot_s       [3];
  logic        sat_s       [3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  srdhm_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .a(a_s[0]), .b(b_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .prod_top(top_s[0]), .prod_bottom(bot_s[0]), .sat(sat_s[0])
  );

  srdhm_mul_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .a(a_s[1]), .b(b_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .prod_top(top_s[1]), .prod_bottom(bot_s[1]), .sat(sat_s[1])
  );

  srdhm_mul_seq #(.BITS_PER_CYCLE(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .a(a_s[2]), .b(b_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .prod_top(top_s[2]), .prod_bottom(bot_s[2]), .sat(sat_s[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands until they are accepted; returns just after the accept edge.
  task automatic issue(input int k, input logic [31:0] x, input logic [31:0] y);
    int w = 0;
    while (!in_ready_s[k] && w < 100) begin
      step();
      w++;
    end
    a_s[k]        = x;
    b_s[k]        = y;
    in_valid_s[k] = 1'b1;
    step();
    in_valid_s[k] = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen; bounded.
  task automatic wait_result(input int k, input int exp_lat, input string tag);
    int cnt = 0;
    while (!out_valid_s[k] && cnt < 200) begin
      step();
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'(exp_lat));
  endtask

  // Full operation with out_ready held high; leaves the instance back in IDLE.
  task automatic op(input int k, input logic [31:0] x, input logic [31:0] y,
                    input logic [63:0] exp_p, input logic exp_sat, input int exp_lat,
                    input string tag);
    issue(k, x, y);
    wait_result(k, exp_lat, tag);
    check({tag, "_prod"}, {top_s[k], bot_s[k]}, exp_p);
    check({tag, "_sat"}, 64'(sat_s[k]), 64'(exp_sat));
    step();
    check({tag, "_idle"}, 64'({in_ready_s[k], out_valid_s[k]}), 64'(2'b10));
  endtask

  initial begin
    longint      ref_p;
    logic [31:0] x;
    logic [31:0] y;

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b1;
      a_s[k]         = '0;
      b_s[k]         = '0;
    end
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state of every instance.
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_in_ready", k), 64'(in_ready_s[k]), 64'd1);
      check($sformatf("rst%0d_out_valid", k), 64'(out_valid_s[k]), 64'd0);
      check($sformatf("rst%0d_prod", k), {top_s[k], bot_s[k]}, 64'd0);
      check($sformatf("rst%0d_sat", k), 64'(sat_s[k]), 64'd0);
    end

    // Directed vectors, BITS_PER_CYCLE=4 (latency 8 edges after accept).
    op(0, 32'd3, 32'd5, 64'd15, 1'b0, 8, "basic");
    op(0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 8, "neg2x3");
    op(0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A, 1'b0, 8, "neg7xneg6");
    op(0, 32'd0, 32'hFFFF_FFFB, 64'd0, 1'b0, 8, "zeroxneg5");
    op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 8, "maxpos");
    op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 8, "satcase");
    op(0, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 8, "minx1");
    op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 8, "satcase2");

    // Reset in the third BUSY cycle: results and sat cleared, no output.
    issue(0, 32'd9, 32'd9);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_in_ready", 64'(in_ready_s[0]), 64'd1);
    check("midrst_out_valid", 64'(out_valid_s[0]), 64'd0);
    check("midrst_prod", {top_s[0], bot_s[0]}, 64'd0);
    check("midrst_sat", 64'(sat_s[0]), 64'd0);
    op(0, 32'd4, 32'd4, 64'd16, 1'b0, 8, "after_rst");

    // Backpressure: hold the result in DONE while new operands are offered.
    out_ready_s[0] = 1'b0;
    issue(0, 32'd10, 32'hFFFF_FFFD);
    wait_result(0, 8, "bp");
    check("bp_prod", {top_s[0], bot_s[0]}, 64'hFFFF_FFFF_FFFF_FFE2);
    for (int j = 0; j < 5; j++) begin
      in_valid_s[0] = (j % 2 == 0);
      a_s[0]        = 32'd100 + 32'(j);
      b_s[0]        = 32'd3;
      step();
      check($sformatf("bp_hold%0d_out_valid", j), 64'(out_valid_s[0]), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", j), 64'(in_ready_s[0]), 64'd0);
      check($sformatf("bp_hold%0d_prod", j), {top_s[0], bot_s[0]}, 64'hFFFF_FFFF_FFFF_FFE2);
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    step();
    check("bp_rel_in_ready", 64'(in_ready_s[0]), 64'd1);
    check("bp_rel_out_valid", 64'(out_valid_s[0]), 64'd0);
    check("bp_rel_prod_kept", {top_s[0], bot_s[0]}, 64'hFFFF_FFFF_FFFF_FFE2);
    op(0, 32'd6, 32'd7, 64'd42, 1'b0, 8, "bp_next");

    // Parameter sweep against a signed 64-bit reference product.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        x = $urandom();
        y = $urandom();
        if (i == 0) begin
          x = 32'h8000_0000;
          y = 32'h8000_0000;
        end else if (i == 1) begin
          x = 32'd0;
          y = 32'h8000_0000;
        end else if (i == 2) begin
          x = 32'h7FFF_FFFF;
          y = 32'h8000_0000;
        end else if (i % 4 == 3) begin
          x = $urandom_range(0, 255) - 128;
          y = $urandom_range(0, 255) - 128;
        end
        ref_p = longint'($signed(x)) * longint'($signed(y));
        op(k, x, y, 64'(ref_p), (x == 32'h8000_0000) && (y == 32'h8000_0000),
           (k == 1) ? 32 : 4, $sformatf("rnd_bpc%0d_%0d", (k == 1) ? 1 : 8, i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
